// File: rtl/rnd_arbiter_if.sv
// Bundle between the random-word arbiter and its requesters: LFSR word in,
// request bits in, one-hot grant pulse, delivered word and stuck flag out.
interface rnd_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [15:0]      i_rnd;
  logic [N_REQ-1:0] i_req;
  logic [N_REQ-1:0] o_gnt;
  logic [15:0]      o_data;
  logic             o_stuck;

  modport master (output i_rnd, i_req, input o_gnt, o_data, o_stuck);
  modport slave  (input i_rnd, i_req, output o_gnt, o_data, o_stuck);
endinterface

// File: rtl/rnd_arbiter.sv
// Round-robin arbiter handing out LFSR words only after GAP fresh shifts.
// Optional source-stuck detector enabled by defining RND_ARBITER_STUCK_CHK_EN.
module rnd_arbiter #(
  parameter int N_REQ = 4,
  parameter int GAP   = 16
) (
  input logic         clk,
  input logic         rst_n,
  rnd_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(GAP + 1);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {WAIT, READY, GRANT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_q, gnt_nxt;
  logic [15:0]      data_q, data_nxt;
  logic [IDX_W-1:0] last, last_nxt, win, cidx;
  logic             found;
  logic             stuck;
  int               cand;

  // Round-robin search starting just after the previous winner
  always_comb begin
    win   = last;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last) + i) % N_REQ;
      cidx = IDX_W'(cand);
      if (!found && bus.i_req[cidx]) begin
        found = 1'b1;
        win   = cidx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    data_nxt  = data_q;
    last_nxt  = last;
    case (state)
      WAIT: begin
        if (!stuck) begin
          if (cnt == GAP_M1) begin
            state_nxt = READY;
            cnt_nxt   = GAP_C;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      READY: begin
        if (stuck) begin
          state_nxt = WAIT;
        end else if (found) begin
          state_nxt     = GRANT;
          gnt_nxt[win]  = 1'b1;
          data_nxt      = bus.i_rnd;
          cnt_nxt       = '0;
          last_nxt      = win;
        end
      end
      GRANT: begin
        state_nxt = WAIT;
        cnt_nxt   = ONE;
      end
      default: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT;
      cnt    <= '0;
      gnt_q  <= '0;
      data_q <= 16'h0000;
      last   <= LAST_RST;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      gnt_q  <= gnt_nxt;
      data_q <= data_nxt;
      last   <= last_nxt;
    end
  end

`ifdef RND_ARBITER_STUCK_CHK_EN
  logic [15:0]      prev_rnd;
  logic             prev_vld;
  logic [CNT_W-1:0] run;
  logic             stuck_q;

  // prev_rnd is only trusted once prev_vld is set, so it needs no reset
  always_ff @(posedge clk) begin
    prev_rnd <= bus.i_rnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vld <= 1'b0;
      run      <= '0;
      stuck_q  <= 1'b0;
    end else begin
      prev_vld <= 1'b1;
      if (prev_vld && (bus.i_rnd == prev_rnd)) begin
        if (run != GAP_C) run <= run + ONE;
        if (run == GAP_M1) stuck_q <= 1'b1;
      end else begin
        run <= '0;
      end
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

  assign bus.o_gnt   = gnt_q;
  assign bus.o_data  = data_q;
  assign bus.o_stuck = stuck;
endmodule
